// File: rtl/mips_isa_pkg.sv
// MIPS32 opcode/funct encodings and the in-flight destination record
// shared by the decode-stage hazard scoreboard.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       is_load;
        logic [4:0] dst;
    } dest_rec_t;

endpackage

// File: rtl/dest_src_decode.sv
// Combinational decode of destination, write-enable, load flag and
// source-register usage for the instruction in ID.
module dest_src_decode
    import mips_isa_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_dst,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic        o_we,
    output logic        o_is_load,
    output logic        o_rs_used,
    output logic        o_rt_used
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd;
    logic       r_alu;
    logic       r_shift_imm;
    logic       unused_shamt;

    assign opcode       = i_instr[31:26];
    assign funct        = i_instr[5:0];
    assign rd           = i_instr[15:11];
    assign o_rs         = i_instr[25:21];
    assign o_rt         = i_instr[20:16];
    assign unused_shamt = ^i_instr[10:6];

    always_comb begin
        r_alu       = 1'b0;
        r_shift_imm = 1'b0;
        case (funct)
            FN_SLL, FN_SRL, FN_SRA: begin
                r_alu       = 1'b1;
                r_shift_imm = 1'b1;
            end
            FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: r_alu = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        o_dst     = REG_ZERO;
        o_we      = 1'b0;
        o_is_load = 1'b0;
        o_rs_used = 1'b0;
        o_rt_used = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (r_alu) begin
                    o_dst     = rd;
                    o_we      = 1'b1;
                    o_rs_used = ~r_shift_imm;
                    o_rt_used = 1'b1;
                end else if (funct == FN_JR) begin
                    o_rs_used = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                o_dst     = o_rt;
                o_we      = 1'b1;
                o_rs_used = 1'b1;
            end
            OP_LUI: begin
                o_dst = o_rt;
                o_we  = 1'b1;
            end
            OP_LW: begin
                o_dst     = o_rt;
                o_we      = 1'b1;
                o_is_load = 1'b1;
                o_rs_used = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                o_rs_used = 1'b1;
                o_rt_used = 1'b1;
            end
            OP_JAL: begin
                o_dst = REG_RA;
                o_we  = 1'b1;
            end
            default: ;
        endcase
        // $0 is hardwired, so a write to it must never look like a producer
        if (o_dst == REG_ZERO) o_we = 1'b0;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight destinations, raises load-use
// stalls and registers per-operand forwarding selects for EX.
module hazard_scoreboard
    import mips_isa_pkg::*;
#(
    parameter  int STAGES   = 3,
    parameter  int LOAD_LAT = 1,
    parameter  int RA_BITS  = 5,
    localparam int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_instr,
    input  logic               i_valid,
    input  logic               i_hold,
    input  logic               i_flush,
    output logic               o_stall,
    output logic [SEL_W-1:0]   o_fwd_rs_sel,
    output logic [SEL_W-1:0]   o_fwd_rt_sel,
    output logic [RA_BITS-1:0] o_dst,
    output logic               o_we
);

    dest_rec_t [STAGES-1:0] tbl;

    logic [4:0]     dec_dst, dec_rs, dec_rt;
    logic           dec_we, dec_is_load, dec_rs_used, dec_rt_used;
    logic [SEL_W:0] rs_m, rt_m;
    logic           issue;

    dest_src_decode u_decode (
        .i_instr   (i_instr),
        .o_dst     (dec_dst),
        .o_rs      (dec_rs),
        .o_rt      (dec_rt),
        .o_we      (dec_we),
        .o_is_load (dec_is_load),
        .o_rs_used (dec_rs_used),
        .o_rt_used (dec_rt_used)
    );

    // Returns {hazard, select}; scanning oldest-to-youngest lets the youngest win.
    function automatic logic [SEL_W:0] match_src(input dest_rec_t [STAGES-1:0] t,
                                                 input logic [4:0] src,
                                                 input logic used);
        logic [SEL_W:0] r;
        r = '0;
        if (used && src != REG_ZERO) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (t[k].valid && t[k].we && t[k].dst == src)
                    r = {t[k].is_load && (k < LOAD_LAT), SEL_W'(k + 1)};
            end
        end
        return r;
    endfunction

    // ID stage: hazard detection and issue decision
    always_comb begin
        rs_m    = match_src(tbl, dec_rs, dec_rs_used);
        rt_m    = match_src(tbl, dec_rt, dec_rt_used);
        o_stall = i_valid & ~i_flush & (rs_m[SEL_W] | rt_m[SEL_W]);
        issue   = i_valid & ~o_stall & ~i_flush;
    end

    // ID -> EX boundary: in-flight table shift and registered EX outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tbl          <= '0;
            o_fwd_rs_sel <= '0;
            o_fwd_rt_sel <= '0;
            o_dst        <= '0;
            o_we         <= 1'b0;
        end else if (!i_hold) begin
            for (int k = STAGES - 1; k > 0; k--) tbl[k] <= tbl[k-1];
            tbl[0]       <= issue ? '{valid: 1'b1, we: dec_we, is_load: dec_is_load, dst: dec_dst}
                                  : '0;
            o_fwd_rs_sel <= issue ? rs_m[SEL_W-1:0] : '0;
            o_fwd_rt_sel <= issue ? rt_m[SEL_W-1:0] : '0;
            o_dst        <= issue ? RA_BITS'(dec_dst) : '0;
            o_we         <= issue & dec_we;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with STAGES=3, LOAD_LAT=1.
module tb_hazard_scoreboard;

    localparam int STAGES = 3;
    localparam int SEL_W  = $clog2(STAGES + 1);

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [31:0]      i_instr;
    logic             i_valid, i_hold, i_flush;
    logic             o_stall;
    logic [SEL_W-1:0] o_fwd_rs_sel, o_fwd_rt_sel;
    logic [4:0]       o_dst;
    logic             o_we;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(.STAGES(STAGES), .LOAD_LAT(1), .RA_BITS(5)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_instr      (i_instr),
        .i_valid      (i_valid),
        .i_hold       (i_hold),
        .i_flush      (i_flush),
        .o_stall      (o_stall),
        .o_fwd_rs_sel (o_fwd_rs_sel),
        .o_fwd_rt_sel (o_fwd_rt_sel),
        .o_dst        (o_dst),
        .o_we         (o_we)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_hold  = 1'b0;
        repeat (STAGES) step();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_hold  = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b1;
        i_instr = rtype(1, 2, 3, 'h21);
        #2;
        n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0d expected 0", o_stall); end
        step();
        n_cmp++; if ({o_fwd_rs_sel, o_fwd_rt_sel, o_dst, o_we} !== '0) begin n_err++;
            $display("FAIL reset_outputs: got rs=%0d rt=%0d dst=%0d we=%0d expected all 0", o_fwd_rs_sel, o_fwd_rt_sel, o_dst, o_we); end
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        drain();
        i_valid = 1'b1;
        i_instr = rtype(1, 2, 3, 'h21);            // ADDU $3,$1,$2
        #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall0: got %0d expected 0", o_stall); end
        step();
        n_cmp++; if (o_dst !== 5'd3 || o_we !== 1'b1) begin n_err++; $display("FAIL b2b_addu: got dst=%0d we=%0d expected dst=3 we=1", o_dst, o_we); end
        i_instr = rtype(3, 5, 4, 'h23);            // SUBU $4,$3,$5
        #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall1: got %0d expected 0", o_stall); end
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd1 || o_fwd_rt_sel !== 2'd0 || o_dst !== 5'd4) begin n_err++;
            $display("FAIL b2b_subu: got rs=%0d rt=%0d dst=%0d expected rs=1 rt=0 dst=4", o_fwd_rs_sel, o_fwd_rt_sel, o_dst); end
        i_instr = rtype(3, 4, 6, 'h21);            // ADDU $6,$3,$4
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd2 || o_fwd_rt_sel !== 2'd1) begin n_err++;
            $display("FAIL b2b_two_src: got rs=%0d rt=%0d expected rs=2 rt=1", o_fwd_rs_sel, o_fwd_rt_sel); end
    endtask

    task automatic test_load_use();
        drain();
        i_valid = 1'b1;
        i_instr = itype('h23, 9, 8, 0);            // LW $8,0($9)
        step();
        n_cmp++; if (o_dst !== 5'd8 || o_we !== 1'b1) begin n_err++; $display("FAIL lu_lw: got dst=%0d we=%0d expected dst=8 we=1", o_dst, o_we); end
        i_instr = rtype(8, 8, 10, 'h20);           // ADD $10,$8,$8
        #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0d expected 1", o_stall); end
        step();
        n_cmp++; if (o_we !== 1'b0 || o_fwd_rs_sel !== 2'd0 || o_fwd_rt_sel !== 2'd0) begin n_err++;
            $display("FAIL lu_bubble: got we=%0d rs=%0d rt=%0d expected 0 0 0", o_we, o_fwd_rs_sel, o_fwd_rt_sel); end
        n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_end: got %0d expected 0", o_stall); end
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd2 || o_fwd_rt_sel !== 2'd2 || o_dst !== 5'd10 || o_we !== 1'b1) begin n_err++;
            $display("FAIL lu_issue: got rs=%0d rt=%0d dst=%0d we=%0d expected 2 2 10 1", o_fwd_rs_sel, o_fwd_rt_sel, o_dst, o_we); end
    endtask

    task automatic test_zero_dst();
        drain();
        i_valid = 1'b1;
        i_instr = itype('h08, 1, 0, 5);            // ADDI $0,$1,5
        step();
        n_cmp++; if (o_we !== 1'b0) begin n_err++; $display("FAIL zero_addi_we: got %0d expected 0", o_we); end
        i_instr = rtype(0, 0, 2, 'h25);            // OR $2,$0,$0
        #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %0d expected 0", o_stall); end
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd0 || o_fwd_rt_sel !== 2'd0 || o_dst !== 5'd2 || o_we !== 1'b1) begin n_err++;
            $display("FAIL zero_or: got rs=%0d rt=%0d dst=%0d we=%0d expected 0 0 2 1", o_fwd_rs_sel, o_fwd_rt_sel, o_dst, o_we); end
        i_instr = itype('h2B, 2, 7, 4);            // SW $7,4($2)
        step();
        n_cmp++; if (o_we !== 1'b0 || o_fwd_rs_sel !== 2'd1) begin n_err++;
            $display("FAIL zero_sw: got we=%0d rs=%0d expected we=0 rs=1", o_we, o_fwd_rs_sel); end
    endtask

    task automatic test_jal();
        drain();
        i_valid = 1'b1;
        i_instr = {6'h03, 26'h0000100};            // JAL
        step();
        n_cmp++; if (o_dst !== 5'd31 || o_we !== 1'b1) begin n_err++; $display("FAIL jal_dst: got dst=%0d we=%0d expected dst=31 we=1", o_dst, o_we); end
        i_instr = rtype(31, 0, 2, 'h21);           // ADDU $2,$31,$0
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd1 || o_fwd_rt_sel !== 2'd0) begin n_err++;
            $display("FAIL jal_fwd: got rs=%0d rt=%0d expected rs=1 rt=0", o_fwd_rs_sel, o_fwd_rt_sel); end
    endtask

    task automatic test_flush();
        drain();
        i_valid = 1'b1;
        i_instr = itype('h23, 9, 8, 0);            // LW $8,0($9)
        step();
        i_instr = rtype(8, 1, 10, 'h20);           // ADD $10,$8,$1
        i_flush = 1'b1;
        #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %0d expected 0", o_stall); end
        step();
        n_cmp++; if (o_we !== 1'b0 || o_fwd_rs_sel !== 2'd0) begin n_err++;
            $display("FAIL flush_bubble: got we=%0d rs=%0d expected 0 0", o_we, o_fwd_rs_sel); end
        i_flush = 1'b0;
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd2 || o_dst !== 5'd10 || o_we !== 1'b1) begin n_err++;
            $display("FAIL flush_after: got rs=%0d dst=%0d we=%0d expected 2 10 1", o_fwd_rs_sel, o_dst, o_we); end
    endtask

    task automatic test_hold();
        drain();
        i_valid = 1'b1;
        i_instr = itype('h23, 9, 8, 0);            // LW $8,0($9)
        step();
        i_instr = rtype(8, 8, 10, 'h20);           // ADD $10,$8,$8
        i_hold  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (o_stall !== 1'b1 || o_dst !== 5'd8 || o_we !== 1'b1) begin n_err++;
                $display("FAIL hold_frozen%0d: got stall=%0d dst=%0d we=%0d expected 1 8 1", c, o_stall, o_dst, o_we); end
            step();
        end
        i_hold = 1'b0;
        #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL hold_release_stall: got %0d expected 1", o_stall); end
        step();
        n_cmp++; if (o_we !== 1'b0) begin n_err++; $display("FAIL hold_bubble: got we=%0d expected 0", o_we); end
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd2 || o_fwd_rt_sel !== 2'd2 || o_dst !== 5'd10) begin n_err++;
            $display("FAIL hold_issue: got rs=%0d rt=%0d dst=%0d expected 2 2 10", o_fwd_rs_sel, o_fwd_rt_sel, o_dst); end
    endtask

    task automatic test_async_reset();
        drain();
        i_valid = 1'b1;
        i_instr = rtype(1, 2, 3, 'h21);            // ADDU $3,$1,$2
        step();
        i_instr = rtype(1, 2, 4, 'h21);            // ADDU $4,$1,$2
        step();
        i_instr = itype('h23, 9, 8, 0);            // LW $8,0($9)
        step();
        i_instr = rtype(8, 3, 10, 'h20);           // ADD $10,$8,$3
        #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL ares_pre_stall: got %0d expected 1", o_stall); end
        #1;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if ({o_fwd_rs_sel, o_fwd_rt_sel, o_dst, o_we} !== '0 || o_stall !== 1'b0) begin n_err++;
            $display("FAIL ares_outputs: got rs=%0d rt=%0d dst=%0d we=%0d stall=%0d expected all 0",
                     o_fwd_rs_sel, o_fwd_rt_sel, o_dst, o_we, o_stall); end
        #2;
        i_rst_n = 1'b1;
        step();
        n_cmp++; if (o_fwd_rs_sel !== 2'd0 || o_fwd_rt_sel !== 2'd0 || o_dst !== 5'd10 || o_we !== 1'b1) begin n_err++;
            $display("FAIL ares_post: got rs=%0d rt=%0d dst=%0d we=%0d expected 0 0 10 1", o_fwd_rs_sel, o_fwd_rt_sel, o_dst, o_we); end
    endtask

    initial begin
        i_instr = '0;
        i_valid = 1'b0;
        i_hold  = 1'b0;
        i_flush = 1'b0;
        i_rst_n = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_zero_dst();
        test_jal();
        test_flush();
        test_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
